// File: rtl/e_mdu_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
// Latency: none, wires only.
// Backpressure: busy flows back to the hazard unit, which stalls MDU ops held in D.
interface e_mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] out;

    modport master (output start, op, A, B, input busy, out);
    modport slave  (input start, op, A, B, output busy, out);
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Latency: HI/LO written MULT_CYCLES/DIV_CYCLES edges after the start edge; mf* reads are combinational.
// Backpressure: busy = start | count!=0; starts and mt* writes arriving while busy are dropped.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   mdu
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [31:0]   hi, lo;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;
    logic [CW-1:0] count;

    logic          is_mul, is_div, sgn;
    logic [63:0]   a_ext, b_ext, prod;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic [31:0]   res_hi, res_lo;
    logic          res_wr;

    always_comb begin
        is_mul = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU);
        is_div = (mdu.op == OP_DIV)  || (mdu.op == OP_DIVU);
        sgn    = (mdu.op == OP_MULT) || (mdu.op == OP_DIV);

        // The low 64 bits of a product of sign/zero-extended operands are the
        // same for signed and unsigned, so one multiplier serves both.
        a_ext = {{32{sgn & mdu.A[31]}}, mdu.A};
        b_ext = {{32{sgn & mdu.B[31]}}, mdu.B};
        prod  = a_ext * b_ext;

        // Divide magnitudes, then restore signs; 0x80000000 / -1 falls out as
        // 0x80000000 with zero remainder without a special case.
        a_mag = (sgn && mdu.A[31]) ? -mdu.A : mdu.A;
        b_mag = (sgn && mdu.B[31]) ? -mdu.B : mdu.B;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (sgn && (mdu.A[31] ^ mdu.B[31])) ? -q_mag : q_mag;
        rem = (sgn && mdu.A[31]) ? -r_mag : r_mag;

        res_hi = is_mul ? prod[63:32] : rem;
        res_lo = is_mul ? prod[31:0]  : quo;
        res_wr = is_mul || (mdu.B != 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            count   <= '0;
        end else if (count != '0) begin
            count <= count - 1'b1;
            if (count == CW'(1) && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (mdu.start && (is_mul || is_div)) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            count   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (!mdu.start && mdu.op == OP_MTHI) begin
            hi <= mdu.A;
        end else if (!mdu.start && mdu.op == OP_MTLO) begin
            lo <= mdu.A;
        end
    end

    always_comb begin
        mdu.busy = mdu.start | (count != '0);
        case (mdu.op)
            OP_MFHI: mdu.out = hi;
            OP_MFLO: mdu.out = lo;
            default: mdu.out = '0;
        endcase
    end
endmodule

// File: tb/tb_e_mdu.sv
// Randomized and directed bench for e_mdu against a timestamp-based behavioural model.
// Latency: n/a. Backpressure: n/a.
// Drives inputs just after posedge, samples outputs on negedge.
module tb_e_mdu;
    localparam int NM = 5;
    localparam int ND = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_if mif ();
    e_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (.clk(clk), .reset(reset), .mdu(mif.slave));

    int n_chk = 0;
    int n_fail = 0;

    // Model: architectural HI/LO plus a pending result that lands at edge number done_edge.
    longint      cyc = 0;
    longint      done_edge = -1;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          p_wr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_start(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] up;
        p_wr = 1'b1;
        case (o)
            4'd1: begin
                q = longint'($signed(a)) * longint'($signed(b));
                p_hi = q[63:32]; p_lo = q[31:0];
            end
            4'd2: begin
                up = {32'b0, a} * {32'b0, b};
                p_hi = up[63:32]; p_lo = up[31:0];
            end
            4'd3: begin
                if (b == 32'd0) p_wr = 1'b0;
                else begin
                    sa = longint'($signed(a)); sb = longint'($signed(b));
                    q = sa / sb; r = sa % sb;
                    p_lo = q[31:0]; p_hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) p_wr = 1'b0;
                else begin p_lo = a / b; p_hi = a % b; end
            end
        endcase
        done_edge = cyc + ((o <= 4'd2) ? NM : ND);
    endtask

    // One clock cycle: apply inputs, check against model mid-cycle, then advance model at the edge.
    task automatic step(input bit st, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit rst, output logic [31:0] got_out, output logic got_busy);
        logic        e_busy;
        logic [31:0] e_out;
        mif.start = st; mif.op = o; mif.A = a; mif.B = b; reset = rst;
        @(negedge clk);
        e_busy = st | (cyc <= done_edge);
        e_out  = (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'd0;
        got_out = mif.out; got_busy = mif.busy;
        chk("busy", {31'b0, got_busy}, {31'b0, e_busy});
        chk("out", got_out, e_out);
        @(posedge clk);
        if (rst) begin
            m_hi = '0; m_lo = '0; p_wr = 1'b0; done_edge = -1;
        end else if (cyc <= done_edge) begin
            if (cyc == done_edge && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (st && o >= 4'd1 && o <= 4'd4) model_start(o, a, b);
        else if (!st && o == 4'd7) m_hi = a;
        else if (!st && o == 4'd8) m_lo = a;
        cyc++;
        #1;
    endtask

    task automatic idle(output logic busy_o);
        logic [31:0] d;
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, d, busy_o);
    endtask

    // Start an op and count the cycles busy is seen high, start cycle included.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int len);
        logic [31:0] d;
        logic        bz;
        step(1'b1, o, a, b, 1'b0, d, bz);
        len = bz ? 1 : 0;
        for (int k = 0; k < 64; k++) begin
            idle(bz);
            if (!bz) break;
            len++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        logic bz;
        step(1'b0, 4'd5, 32'd0, 32'd0, 1'b0, h, bz);
        step(1'b0, 4'd6, 32'd0, 32'd0, 1'b0, l, bz);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] h, l, o, saved_lo;
        logic        bz;
        int          len;

        mif.start = 1'b0; mif.op = 4'd0; mif.A = '0; mif.B = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        read_hilo(h, l);
        chk("rst_hi", h, 32'd0);
        chk("rst_lo", l, 32'd0);
        idle(bz);
        chk("rst_busy", {31'b0, bz}, 32'd0);

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, len);
        chk("mult_len", len, 32'd6);
        read_hilo(h, l);
        chk("mult_hi", h, 32'hFFFF_FFFF);
        chk("mult_lo", l, 32'hFFFF_FFFA);

        issue(4'd2, 32'hFFFF_FFFE, 32'd3, len);
        chk("multu_len", len, 32'd6);
        read_hilo(h, l);
        chk("multu_hi", h, 32'h0000_0002);
        chk("multu_lo", l, 32'hFFFF_FFFA);

        step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, o, bz);
        for (int i = 1; i <= ND; i++) begin
            step(1'b0, (i == ND) ? 4'd5 : 4'd0, 32'd0, 32'd0, 1'b0, o, bz);
            if (i == ND) begin
                chk("div_last_busy", {31'b0, bz}, 32'd1);
                chk("div_old_hi", o, 32'h0000_0002);
            end
        end
        read_hilo(h, l);
        chk("div_hi", h, 32'hFFFF_FFFF);
        chk("div_lo", l, 32'hFFFF_FFFD);

        issue(4'd4, 32'hFFFF_FFF9, 32'd2, len);
        chk("divu_len", len, 32'd11);
        read_hilo(h, l);
        chk("divu_hi", h, 32'h0000_0001);
        chk("divu_lo", l, 32'h7FFF_FFFC);
        saved_lo = 32'h7FFF_FFFC;

        step(1'b0, 4'd7, 32'h1234_5678, 32'd0, 1'b0, o, bz);
        step(1'b0, 4'd5, 32'd0, 32'd0, 1'b0, o, bz);
        chk("mthi", o, 32'h1234_5678);
        issue(4'd3, 32'd5, 32'd0, len);
        chk("div0_len", len, 32'd11);
        read_hilo(h, l);
        chk("div0_hi", h, 32'h1234_5678);
        chk("div0_lo", l, saved_lo);

        step(1'b1, 4'd1, 32'd2, 32'd3, 1'b0, o, bz);
        step(1'b0, 4'd8, 32'hDEAD_BEEF, 32'd0, 1'b0, o, bz);
        step(1'b1, 4'd3, 32'd9, 32'd3, 1'b0, o, bz);
        for (int k = 0; k < 64; k++) begin
            idle(bz);
            if (!bz) break;
        end
        read_hilo(h, l);
        chk("ign_hi", h, 32'd0);
        chk("ign_lo", l, 32'd6);

        step(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, o, bz);
        idle(bz);
        idle(bz);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, o, bz);
        idle(bz);
        chk("rst_mid_busy", {31'b0, bz}, 32'd0);
        read_hilo(h, l);
        chk("rst_mid_hi", h, 32'd0);
        chk("rst_mid_lo", l, 32'd0);
        repeat (10) idle(bz);
        read_hilo(h, l);
        chk("rst_late_hi", h, 32'd0);
        chk("rst_late_lo", l, 32'd0);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, len);
        read_hilo(h, l);
        chk("ovf_hi", h, 32'd0);
        chk("ovf_lo", l, 32'h8000_0000);

        for (int n = 0; n < 3000; n++) begin
            bit          st, rst;
            logic [3:0]  op;
            st  = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 249) == 0);
            op  = st ? (($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)))
                     : 4'($urandom_range(0, 15));
            step(st, op, pick(), pick(), rst, o, bz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. It consumes the two forwarded register operands produced by the decode-stage register file and the D/E pipeline register. It executes mult/multu/div/divu with a fixed multi-cycle latency and owns the HI/LO registers (mfhi/mflo/mthi/mtlo). It exports a busy flag that the hazard unit uses to stall any MDU instruction held in D.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu start (≥1)
- DIV_CYCLES, 10, busy cycles after a div/divu start (≥1)

Ports (clock and reset first):
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high; clock clk
- start  input  1  E-stage instruction is mult/multu/div/divu; qualifies op
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- busy  output  1  start | (count != 0), combinational
- out  output  32  HI when op==5, LO when op==6, else 0; combinational from current HI/LO

## Operation
- State: HI[31:0], LO[31:0], count (wide enough for max(MULT_CYCLES, DIV_CYCLES)), pend_hi, pend_lo, pend_wr.
- Idle (count==0) and start with op 1–4 at an edge: compute the result from A/B and latch it into pend_hi/pend_lo. Load count with MULT_CYCLES (op 1,2) or DIV_CYCLES (op 3,4).
- mult: signed 32×32→64; HI = product[63:32], LO = product[31:0]. multu: unsigned, same split.
- div: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign. divu: unsigned quotient and remainder.
- 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu): pend_wr=0. The full DIV_CYCLES busy period still runs, and HI/LO stay unchanged at completion.
- Busy (count!=0): decrement on each edge. On the edge where count goes 1→0, write pend_hi/pend_lo to HI/LO if pend_wr.
- start while count!=0: ignored. No relatch, no count reload. The hazard unit guarantees this does not happen.
- mthi/mtlo (op 7/8, start=0) with count==0: HI or LO ← A at the edge. With count!=0: ignored.
- mfhi/mflo: pure read of the architectural HI/LO, never the pending values.
- start=1 with op outside 1–4: treated as none; busy still follows start.

## Timing
- Reset values: HI=0, LO=0, count=0, pend_wr=0. Therefore busy=start and out=0 (op≠5/6) or 0 (op 5/6).
- Reset has priority over everything. Reset mid-operation clears count and discards the pending result, and no late HI/LO write occurs.
- Let edge E0 sample start. busy is high in the start cycle (combinationally) plus the N cycles after E0, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO update at edge E0+N. mfhi/mflo in the cycle after E0+N returns the new value.
- mthi/mtlo: write at the sampling edge. mfhi/mflo in the next cycle sees it. Same-cycle read returns the old value (no bypass).
- Back-to-back: a new start is accepted in the first cycle where count==0. That is cycle E0+N, giving a throughput of one op per N+1 cycles at most.

## Test plan
- mult A=0xFFFFFFFE, B=3 → busy for 1+5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9, B=2 → busy 1+10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with the same operands → LO=0x7FFFFFFC, HI=0x00000001. mfhi the cycle before completion returns the old HI.
- mthi A=0x12345678 → mfhi next cycle out=0x12345678. div A=5, B=0 → busy 11 cycles, HI stays 0x12345678, LO unchanged.
- Start mult A=2, B=3. While busy: apply mtlo A=0xDEADBEEF, then start div A=9, B=3. Both are ignored, and the final result is HI=0, LO=6.
- Start div, assert reset in the 4th busy cycle → next cycle busy=0, HI=LO=0. No HI/LO change in the following 10 cycles.
- div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
